alu_share_arbiter: RTL and testbench

Two-requester arbiter that time-shares the single-cycle combinational ALU between two issuing agents, e.g. the integer pipeline and the branch/address unit. Each requester presents operands and a 4-bit ALU control code through a valid/ready handshake. The arbiter drives the shared ALU, captures `result` and `zero` into a per-requester response register, and returns them through a second valid/ready handshake. Grants are round-robin with response-slot backpressure.

---
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters.
// Each requester owns a response slot; a full, undrained slot blocks only its own requester.
module alu_share_slot #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grant,
    input  logic              drain,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [CNT_W-1:0]  grant_cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            grant_cnt  <= '0;
        end else if (grant) begin
            // a grant wins over a simultaneous drain so the slot refills back-to-back
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            if (grant_cnt != '1)
                grant_cnt <= grant_cnt + CNT_W'(1);
        end else if (drain) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              last_grant,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);
    localparam int NUM_REQ = 2;

    logic [NUM_REQ-1:0]             req_valid, rsp_ready, rsp_valid, rsp_zero, elig, gnt;
    logic [NUM_REQ-1:0][DATA_W-1:0] rsp_result;
    logic [NUM_REQ-1:0][CNT_W-1:0]  grant_cnt;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign elig      = req_valid & (~rsp_valid | rsp_ready);

    always_comb begin
        gnt    = '0;
        gnt[0] = elig[0] && (!elig[1] || last_grant);
        gnt[1] = elig[1] && (!elig[0] || !last_grant);
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (gnt[0]) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (gnt[1]) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
    end

    // reset to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (gnt[0])
            last_grant <= 1'b0;
        else if (gnt[1])
            last_grant <= 1'b1;
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        alu_share_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .grant      (gnt[i]),
            .drain      (rsp_ready[i]),
            .alu_result (alu_result),
            .alu_zero   (alu_zero),
            .rsp_valid  (rsp_valid[i]),
            .rsp_result (rsp_result[i]),
            .rsp_zero   (rsp_zero[i]),
            .grant_cnt  (grant_cnt[i])
        );
    end

    assign req0_ready  = gnt[0];
    assign req1_ready  = gnt[1];
    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = rsp_result[0];
    assign rsp1_result = rsp_result[1];
    assign rsp0_zero   = rsp_zero[0];
    assign rsp1_zero   = rsp_zero[1];
    assign grant_cnt0  = grant_cnt[0];
    assign grant_cnt1  = grant_cnt[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural RV-style ALU on the shared port.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, last_grant;
    logic [15:0] grant_cnt0, grant_cnt1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
        .last_grant(last_grant), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // shared ALU: branch codes compute a-b and report taken on zero
    always_comb begin
        alu_result = alu_a - alu_b;
        alu_zero   = 1'b0;
        case (alu_ctrl)
            4'h0: alu_result = alu_a + alu_b;
            4'h2: alu_result = alu_a & alu_b;
            4'h3: alu_result = alu_a | alu_b;
            4'h4: alu_result = alu_a ^ alu_b;
            4'h5: alu_result = alu_a << alu_b[4:0];
            4'h6: alu_result = alu_a >> alu_b[4:0];
            4'h7: alu_result = $signed(alu_a) >>> alu_b[4:0];
            4'h8: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'h9: alu_result = {31'd0, alu_a < alu_b};
            default: ;
        endcase
        case (alu_ctrl)
            4'hA: alu_zero = (alu_a == alu_b);
            4'hB: alu_zero = (alu_a != alu_b);
            4'hC: alu_zero = ($signed(alu_a) < $signed(alu_b));
            4'hD: alu_zero = ($signed(alu_a) >= $signed(alu_b));
            4'hE: alu_zero = (alu_a < alu_b);
            4'hF: alu_zero = (alu_a >= alu_b);
            default: alu_zero = (alu_result == 32'd0);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 0; req0_b = 0; req0_ctrl = 4'h0;
        req1_valid = 1'b1; req1_a = 0; req1_b = 0; req1_ctrl = 4'h0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        tick(); tick();
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
        chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
        chk("rst_last", 32'(last_grant), 32'd1);
        chk("rst_result0", rsp0_result, 32'd0);

        rst_n = 1'b1;
        #1;
        chk("first_ready0", 32'(req0_ready), 32'd1);
        chk("first_ready1", 32'(req1_ready), 32'd0);
        tick();
        chk("first_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("first_last", 32'(last_grant), 32'd0);
        chk("first_rsp1_valid", 32'(rsp1_valid), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // single op: ADD 5+7
        req0_valid = 1'b1; req0_a = 5; req0_b = 7; req0_ctrl = 4'h0;
        #1;
        chk("add_ready0", 32'(req0_ready), 32'd1);
        chk("add_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("add_alu_a", alu_a, 32'd5);
        tick();
        chk("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("add_result", rsp0_result, 32'd12);
        chk("add_zero", 32'(rsp0_zero), 32'd0);
        chk("add_cnt0", 32'(grant_cnt0), 32'd2);
        req0_valid = 1'b0;
        #1;
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_ctrl", 32'(alu_ctrl), 32'd0);
        tick();
        chk("drain_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("drain_result_held", rsp0_result, 32'd12);

        // branch codes on req1, back-to-back
        req1_valid = 1'b1; req1_a = 3; req1_b = 3; req1_ctrl = 4'hA;
        tick();
        chk("beq_result", rsp1_result, 32'd0);
        chk("beq_zero", 32'(rsp1_zero), 32'd1);
        chk("beq_last", 32'(last_grant), 32'd1);
        req1_a = 32'hFFFF_FFFF; req1_b = 1; req1_ctrl = 4'hC;
        tick();
        chk("blt_result", rsp1_result, 32'hFFFF_FFFE);
        chk("blt_zero", 32'(rsp1_zero), 32'd1);
        req1_ctrl = 4'hF;
        tick();
        chk("bgeu_zero", 32'(rsp1_zero), 32'd1);
        chk("bgeu_cnt1", 32'(grant_cnt1), 32'd3);
        chk("bgeu_valid", 32'(rsp1_valid), 32'd1);
        req1_valid = 1'b0;
        tick();

        // reset mid-operation with both requesting and a response held
        req0_valid = 1'b1; req0_a = 1; req0_b = 2; req0_ctrl = 4'h0;
        req1_valid = 1'b1; req1_a = 10; req1_b = 20; req1_ctrl = 4'h0;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid0", 32'(rsp0_valid), 32'd0);
        chk("mid_rst_valid1", 32'(rsp1_valid), 32'd0);
        chk("mid_rst_cnt1", 32'(grant_cnt1), 32'd0);
        chk("mid_rst_result1", rsp1_result, 32'd0);
        rst_n = 1'b1;

        // full contention: grants alternate starting with req0
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_ready1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("cont_alu_a", alu_a, (i % 2 == 0) ? 32'd1 : 32'd10);
            tick();
        end
        chk("cont_cnt0", 32'(grant_cnt0), 32'd3);
        chk("cont_cnt1", 32'(grant_cnt1), 32'd3);
        chk("cont_result0", rsp0_result, 32'd3);
        chk("cont_result1", rsp1_result, 32'd30);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // backpressure on slot 0
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 9; req0_b = 9; req0_ctrl = 4'h1;
        tick();
        chk("sub_valid", 32'(rsp0_valid), 32'd1);
        chk("sub_result", rsp0_result, 32'd0);
        chk("sub_zero", 32'(rsp0_zero), 32'd1);
        req0_a = 1; req0_b = 1; req0_ctrl = 4'h0;
        req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = 4'h4;
        #1;
        chk("bp_ready0", 32'(req0_ready), 32'd0);
        chk("bp_ready1", 32'(req1_ready), 32'd1);
        tick();
        chk("xor_result", rsp1_result, 32'hFF);
        chk("xor_zero", 32'(rsp1_zero), 32'd0);
        chk("bp_held_result", rsp0_result, 32'd0);
        chk("bp_held_zero", 32'(rsp0_zero), 32'd1);
        req1_valid = 1'b0;
        tick();
        chk("bp_still_valid", 32'(rsp0_valid), 32'd1);
        chk("bp_still_result", rsp0_result, 32'd0);
        rsp0_ready = 1'b1;
        #1;
        chk("refill_ready0", 32'(req0_ready), 32'd1);
        tick();
        chk("refill_valid", 32'(rsp0_valid), 32'd1);
        chk("refill_result", rsp0_result, 32'd2);
        chk("refill_zero", 32'(rsp0_zero), 32'd0);
        req0_valid = 1'b0;
        tick();

        // counter saturation
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_ctrl = 4'h0;
        repeat (65535) tick();
        chk("sat_cnt0_reach", 32'(grant_cnt0), 32'hFFFF);
        repeat (2) tick();
        chk("sat_cnt0_hold", 32'(grant_cnt0), 32'hFFFF);
        chk("sat_cnt1", 32'(grant_cnt1), 32'd0);
        req0_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
